// File: rtl/ship_plot_scheduler.sv
// Purpose: single writer for the VGA pixel port; erases and redraws the 3x3 ship sprite and interleaves bullet pixel writes.
// Latency: redraw is 20 cycles from acceptance (11 when nothing is on screen yet); a bullet pixel is issued 2 cycles after its request is sampled.
// Backpressure: the VGA port never stalls; blt_req must be held until blt_ack, and dir_valid is dropped (not queued) while busy.
module ship_plot_scheduler #(
  parameter logic [7:0] X0          = 8'd79,
  parameter logic [6:0] Y0          = 7'd60,
  parameter logic [2:0] SHIP_COLOUR = 3'b111,
  parameter logic [2:0] BG_COLOUR   = 3'b000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       dir_valid,
  input  logic [1:0] dir,
  input  logic       blt_req,
  input  logic [7:0] blt_x,
  input  logic [6:0] blt_y,
  input  logic [2:0] blt_colour,
  output logic       blt_ack,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic [1:0] cur_dir,
  output logic       frame_done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ERASE = 3'd1,
    DRAW  = 3'd2,
    DONE  = 3'd3,
    BLT   = 3'd4
  } state_t;

  localparam logic [3:0] LAST_CELL = 4'd8;

  state_t     state, state_nxt;
  logic [3:0] idx, idx_nxt;
  logic [1:0] new_dir, new_dir_nxt;
  logic       drawn, drawn_nxt;

  logic       blt_ack_nxt;
  logic [7:0] x_nxt;
  logic [6:0] y_nxt;
  logic [2:0] colour_nxt;
  logic       plot_nxt;
  logic       busy_nxt;
  logic [1:0] cur_dir_nxt;
  logic       frame_done_nxt;

  // Column within the 3x3 cell grid for a row-major cell index.
  function automatic logic [1:0] col_of(input logic [3:0] i);
    case (i)
      4'd0, 4'd3, 4'd6: col_of = 2'd0;
      4'd1, 4'd4, 4'd7: col_of = 2'd1;
      default:          col_of = 2'd2;
    endcase
  endfunction

  // Row within the 3x3 cell grid for a row-major cell index.
  function automatic logic [1:0] row_of(input logic [3:0] i);
    case (i)
      4'd0, 4'd1, 4'd2: row_of = 2'd0;
      4'd3, 4'd4, 4'd5: row_of = 2'd1;
      default:          row_of = 2'd2;
    endcase
  endfunction

  // Sprite masks written as they look on screen: the leftmost digit is
  // the top-left cell, so cell k lives at bit (8 - k).
  function automatic logic [8:0] mask_of(input logic [1:0] d);
    case (d)
      2'b00:   mask_of = 9'b010_111_101; // up
      2'b01:   mask_of = 9'b101_111_010; // down
      2'b10:   mask_of = 9'b110_011_110; // right
      default: mask_of = 9'b011_110_011; // left
    endcase
  endfunction

  logic [7:0] cell_x;
  logic [6:0] cell_y;
  logic [8:0] draw_mask;
  logic [3:0] mask_sel;
  logic       cell_set;

  assign cell_x    = X0 + {6'd0, col_of(idx)};
  assign cell_y    = Y0 + {5'd0, row_of(idx)};
  assign draw_mask = mask_of(new_dir);
  assign mask_sel  = LAST_CELL - idx;
  assign cell_set  = draw_mask[mask_sel];

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    new_dir_nxt    = new_dir;
    drawn_nxt      = drawn;
    busy_nxt       = busy;
    cur_dir_nxt    = cur_dir;
    x_nxt          = x;
    y_nxt          = y;
    colour_nxt     = colour;
    plot_nxt       = 1'b0;
    blt_ack_nxt    = 1'b0;
    frame_done_nxt = 1'b0;

    case (state)
      IDLE: begin
        // A redraw always beats a bullet request arriving in the same cycle.
        if (dir_valid) begin
          new_dir_nxt = dir;
          busy_nxt    = 1'b1;
          idx_nxt     = 4'd0;
          state_nxt   = drawn ? ERASE : DRAW;
        end else if (blt_req) begin
          state_nxt = BLT;
        end
      end

      ERASE: begin
        // Blank all nine cells; cheaper than tracking the old mask.
        x_nxt      = cell_x;
        y_nxt      = cell_y;
        colour_nxt = BG_COLOUR;
        plot_nxt   = 1'b1;
        if (idx == LAST_CELL) begin
          idx_nxt   = 4'd0;
          state_nxt = DRAW;
        end else begin
          idx_nxt = idx + 4'd1;
        end
      end

      DRAW: begin
        // Clear mask cells become dead cycles; the pixel bus keeps its last value.
        if (cell_set) begin
          x_nxt      = cell_x;
          y_nxt      = cell_y;
          colour_nxt = SHIP_COLOUR;
          plot_nxt   = 1'b1;
        end
        if (idx == LAST_CELL) begin
          state_nxt = DONE;
        end else begin
          idx_nxt = idx + 4'd1;
        end
      end

      DONE: begin
        cur_dir_nxt    = new_dir;
        drawn_nxt      = 1'b1;
        busy_nxt       = 1'b0;
        frame_done_nxt = 1'b1;
        state_nxt      = IDLE;
      end

      BLT: begin
        x_nxt       = blt_x;
        y_nxt       = blt_y;
        colour_nxt  = blt_colour;
        plot_nxt    = 1'b1;
        blt_ack_nxt = 1'b1;
        state_nxt   = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset clears everything at once, mid-redraw included.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      idx        <= 4'd0;
      new_dir    <= 2'b00;
      drawn      <= 1'b0;
      x          <= 8'd0;
      y          <= 7'd0;
      colour     <= 3'd0;
      plot       <= 1'b0;
      blt_ack    <= 1'b0;
      busy       <= 1'b0;
      cur_dir    <= 2'b00;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      new_dir    <= new_dir_nxt;
      drawn      <= drawn_nxt;
      x          <= x_nxt;
      y          <= y_nxt;
      colour     <= colour_nxt;
      plot       <= plot_nxt;
      blt_ack    <= blt_ack_nxt;
      busy       <= busy_nxt;
      cur_dir    <= cur_dir_nxt;
      frame_done <= frame_done_nxt;
    end
  end

endmodule

// File: tb/tb_ship_plot_scheduler.sv
// Bench for ship_plot_scheduler: directed redraw/bullet scenarios, a time-based reference model checked every cycle.
// Inputs change 2 time units after a rising edge; outputs are compared on the falling edge.
// The bullet requester holds blt_req until it sees blt_ack.
module tb_ship_plot_scheduler;

  logic       CLOCK_50 = 1'b0;
  logic       resetn;
  logic       dir_valid;
  logic [1:0] dir;
  logic       blt_req;
  logic [7:0] blt_x;
  logic [6:0] blt_y;
  logic [2:0] blt_colour;
  logic       blt_ack;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic [1:0] cur_dir;
  logic       frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  ship_plot_scheduler dut (
    .CLOCK_50   (CLOCK_50),
    .resetn     (resetn),
    .dir_valid  (dir_valid),
    .dir        (dir),
    .blt_req    (blt_req),
    .blt_x      (blt_x),
    .blt_y      (blt_y),
    .blt_colour (blt_colour),
    .blt_ack    (blt_ack),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot),
    .busy       (busy),
    .cur_dir    (cur_dir),
    .frame_done (frame_done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Sprite table straight from the direction drawings, cell k = column k%3, row k/3.
  bit mask_tab [4][9] = '{
    '{0,1,0, 1,1,1, 1,0,1},   // up
    '{1,0,1, 1,1,1, 0,1,0},   // down
    '{1,1,0, 0,1,1, 1,1,0},   // right
    '{0,1,1, 1,1,0, 0,1,1}    // left
  };

  int         m_kind  = 0;     // 0 idle, 1 redraw in progress, 2 bullet pending
  int         m_t     = 0;     // edges elapsed since the redraw was accepted
  int         m_pre   = 0;
  int         m_k     = 0;
  bit         m_drawn = 0;
  bit         m_erase = 0;
  logic [1:0] m_dir   = 2'b00;

  logic       e_plot = 0, e_ack = 0, e_fd = 0, e_busy = 0;
  logic [1:0] e_cur_dir = 2'b00;
  logic [7:0] e_x = 0;
  logic [6:0] e_y = 0;
  logic [2:0] e_col = 0;

  task automatic model_reset();
    m_kind = 0; m_t = 0; m_drawn = 0; m_erase = 0; m_dir = 2'b00;
    e_plot = 0; e_ack = 0; e_fd = 0; e_busy = 0; e_cur_dir = 2'b00;
    e_x = 0; e_y = 0; e_col = 0;
  endtask

  task automatic model_step();
    e_plot = 0; e_ack = 0; e_fd = 0;
    if (m_kind == 0) begin
      if (dir_valid) begin
        m_kind = 1; m_t = 0; m_erase = m_drawn; m_dir = dir; e_busy = 1;
      end else if (blt_req) begin
        m_kind = 2;
      end
    end else if (m_kind == 2) begin
      e_plot = 1; e_ack = 1; e_x = blt_x; e_y = blt_y; e_col = blt_colour;
      m_kind = 0;
    end else begin
      m_t++;
      m_pre = m_erase ? 9 : 0;
      if (m_t <= m_pre) begin
        m_k = m_t - 1;
        e_plot = 1; e_x = 8'(79 + m_k % 3); e_y = 7'(60 + m_k / 3); e_col = 3'b000;
      end else if (m_t <= m_pre + 9) begin
        m_k = m_t - m_pre - 1;
        if (mask_tab[m_dir][m_k]) begin
          e_plot = 1; e_x = 8'(79 + m_k % 3); e_y = 7'(60 + m_k / 3); e_col = 3'b111;
        end
      end else begin
        e_fd = 1; e_busy = 0; e_cur_dir = m_dir; m_drawn = 1; m_kind = 0;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge CLOCK_50 or negedge resetn);
      if (!resetn) model_reset();
      else model_step();
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge CLOCK_50);
      chk("plot",       32'(plot),       32'(e_plot));
      chk("blt_ack",    32'(blt_ack),    32'(e_ack));
      chk("busy",       32'(busy),       32'(e_busy));
      chk("frame_done", 32'(frame_done), 32'(e_fd));
      chk("cur_dir",    32'(cur_dir),    32'(e_cur_dir));
      if (e_plot) begin
        chk("x",      32'(x),      32'(e_x));
        chk("y",      32'(y),      32'(e_y));
        chk("colour", 32'(colour), 32'(e_col));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  // Issue one redraw and watch 24 cycles; report draw pattern, erase count and frame_done cycle.
  task automatic redraw(input logic [1:0] d, output logic [8:0] pat, output int n_er, output int fd_at);
    logic [31:0] hist;
    hist = 0; pat = 0; n_er = 0; fd_at = -1;
    dir = d; dir_valid = 1'b1;
    @(posedge CLOCK_50);
    #2 dir_valid = 1'b0;
    for (int n = 1; n <= 24; n++) begin
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      if (plot === 1'b1) hist[5'(n)] = 1'b1;
      if (plot === 1'b1 && colour === 3'b000) n_er++;
      if (frame_done === 1'b1 && fd_at < 0) fd_at = n;
    end
    if (fd_at >= 9)
      for (int k = 0; k < 9; k++) pat[4'(8 - k)] = hist[5'(fd_at - 9 + k)];
  endtask

  initial begin
    logic [8:0]  pat;
    logic [31:0] ack_hist;
    int          n_er, fd_at, ack_at, n_ack, n_plot, n_fd;

    resetn = 1'b0; dir_valid = 1'b0; dir = 2'b00; blt_req = 1'b0;
    blt_x = 8'd0; blt_y = 7'd0; blt_colour = 3'd0;
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    chk("reset_plot",    32'(plot),       32'd0);
    chk("reset_busy",    32'(busy),       32'd0);
    chk("reset_cur_dir", 32'(cur_dir),    32'd0);
    chk("reset_xy",      32'({x, y}),     32'd0);
    chk("reset_fd_ack",  32'({frame_done, blt_ack}), 32'd0);
    @(posedge CLOCK_50);
    #2 resetn = 1'b1;

    // 1: first redraw (up), nothing to erase.
    redraw(2'b00, pat, n_er, fd_at);
    chk("t1_fd_cycle", 32'(fd_at),   32'd10);
    chk("t1_erases",   32'(n_er),    32'd0);
    chk("t1_pattern",  32'(pat),     32'b010_111_101);
    chk("t1_cur_dir",  32'(cur_dir), 32'd0);

    // 2: redraw to right, full erase first.
    redraw(2'b10, pat, n_er, fd_at);
    chk("t2_fd_cycle", 32'(fd_at),   32'd19);
    chk("t2_erases",   32'(n_er),    32'd9);
    chk("t2_pattern",  32'(pat),     32'b110_011_110);
    chk("t2_cur_dir",  32'(cur_dir), 32'd2);

    // 3: redraw (down) and bullet in the same cycle; redraw wins.
    dir = 2'b01; dir_valid = 1'b1;
    blt_req = 1'b1; blt_x = 8'd5; blt_y = 7'd7; blt_colour = 3'b100;
    @(posedge CLOCK_50);
    #2 dir_valid = 1'b0;
    ack_at = -1; fd_at = -1;
    for (int n = 1; n <= 26; n++) begin
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      if (frame_done === 1'b1 && fd_at < 0) fd_at = n;
      if (blt_ack === 1'b1 && ack_at < 0) begin
        ack_at = n;
        chk("t3_ack_x",      32'(x),      32'd5);
        chk("t3_ack_y",      32'(y),      32'd7);
        chk("t3_ack_colour", 32'(colour), 32'b100);
        chk("t3_ack_plot",   32'(plot),   32'd1);
        blt_req = 1'b0;
      end
    end
    blt_req = 1'b0;
    chk("t3_fd_cycle",  32'(fd_at),   32'd19);
    chk("t3_ack_cycle", 32'(ack_at),  32'd21);
    chk("t3_cur_dir",   32'(cur_dir), 32'd1);

    // 4: bullet request held for six edges gives three alternate-cycle pixels.
    @(posedge CLOCK_50);
    #2 blt_req = 1'b1; blt_x = 8'd9; blt_y = 7'd3; blt_colour = 3'b010;
    ack_hist = 0; n_ack = 0; n_plot = 0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge CLOCK_50);
      if (n == 6) #2 blt_req = 1'b0;
      @(negedge CLOCK_50);
      if (blt_ack === 1'b1) begin ack_hist[5'(n)] = 1'b1; n_ack++; end
      if (plot === 1'b1) n_plot++;
    end
    chk("t4_ack_count",  32'(n_ack),  32'd3);
    chk("t4_ack_cycles", ack_hist,    32'h54);
    chk("t4_plot_count", 32'(n_plot), 32'd3);

    // 5: second dir_valid mid-redraw is dropped.
    dir = 2'b11; dir_valid = 1'b1;
    @(posedge CLOCK_50);
    #2 dir_valid = 1'b0;
    n_fd = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge CLOCK_50);
      if (n == 6) #2 dir_valid = 1'b0;
      @(negedge CLOCK_50);
      if (frame_done === 1'b1) n_fd++;
      if (n == 5) begin dir = 2'b00; dir_valid = 1'b1; end
    end
    chk("t5_fd_count", 32'(n_fd),    32'd1);
    chk("t5_cur_dir",  32'(cur_dir), 32'd3);

    // 6: reset while erasing cell 4, then a first-time redraw again.
    dir = 2'b01; dir_valid = 1'b1;
    @(posedge CLOCK_50);
    #2 dir_valid = 1'b0;
    repeat (4) @(posedge CLOCK_50);
    #1 chk("t6_erasing", 32'({plot, busy}), 32'b11);
    #1 resetn = 1'b0;
    #1;
    chk("t6_rst_plot",    32'(plot),    32'd0);
    chk("t6_rst_busy",    32'(busy),    32'd0);
    chk("t6_rst_cur_dir", 32'(cur_dir), 32'd0);
    @(posedge CLOCK_50);
    #2 resetn = 1'b1;
    redraw(2'b00, pat, n_er, fd_at);
    chk("t6_fd_cycle", 32'(fd_at), 32'd10);
    chk("t6_erases",   32'(n_er),  32'd0);
    chk("t6_pattern",  32'(pat),   32'b010_111_101);

    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
